// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: writeback stage has priority, long-latency results queue in a FIFO.
// Optional starvation guard enabled by defining WBARB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_rd,
    input  logic [XLEN-1:0]          pipe_wdata,
    input  logic                     lu_valid,
    input  logic [4:0]               lu_rd,
    input  logic [XLEN-1:0]          lu_wdata,
    output logic                     lu_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     stall_pipe,
    output logic [31:0]              busy,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be >= 1");
    end

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] kill_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     cnt_q;
    logic [PW:0]     cnt_d;

    logic full;
    logic push;
    logic pop;
    logic pipe_grant;
    logic head_grant;

    always_comb begin
        full       = (cnt_q == (PW+1)'(DEPTH));
        lu_ready   = !full;
        push       = lu_valid && !full && (lu_rd != 5'd0);
        pipe_grant = pipe_we && (pipe_rd != 5'd0) && !stall_pipe;
        // A killed head is drained on any cycle the pipe does not own the port.
        pop        = !pipe_grant && vld_q[rd_ptr_q];
        head_grant = pop && !kill_q[rd_ptr_q];
        rf_we      = reset && (pipe_grant || head_grant);
        rf_waddr   = pipe_grant ? pipe_rd    : rd_q[rd_ptr_q];
        rf_wdata   = pipe_grant ? pipe_wdata : data_q[rd_ptr_q];
        cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        pend_cnt   = cnt_q;
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !kill_q[i]) begin
                busy[rd_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            vld_q    <= '0;
            kill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // Kill older entries first; a same-cycle push overwrites its slot afterwards and stays live.
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_grant && vld_q[i] && (rd_q[i] == pipe_rd)) begin
                    kill_q[i] <= 1'b1;
                end
            end
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                vld_q[wr_ptr_q]  <= 1'b1;
                kill_q[wr_ptr_q] <= 1'b0;
                rd_q[wr_ptr_q]   <= lu_rd;
                data_q[wr_ptr_q] <= lu_wdata;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

`ifdef WBARB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0] wait_q;
    logic          head_live;
    logic          empty;

    always_comb begin
        empty     = (cnt_q == '0);
        head_live = vld_q[rd_ptr_q] && !kill_q[rd_ptr_q];
    end

    assign stall_pipe = (wait_q == WW'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else if (head_grant || empty) begin
            wait_q <= '0;
        end else if (head_live && pipe_grant) begin
            wait_q <= wait_q + 1'b1;
        end
    end
`else
    assign stall_pipe = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected port writes queued by stimulus, checked by a monitor.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              pipe_we;
    logic [4:0]        pipe_rd;
    logic [XLEN-1:0]   pipe_wdata;
    logic              lu_valid;
    logic [4:0]        lu_rd;
    logic [XLEN-1:0]   lu_wdata;
    logic              lu_ready;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              stall_pipe;
    logic [31:0]       busy;
    logic [$clog2(DEPTH):0] pend_cnt;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .XLEN(XLEN)) dut (
        .clk(clk),
        .reset(reset),
        .pipe_we(pipe_we),
        .pipe_rd(pipe_rd),
        .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid),
        .lu_rd(lu_rd),
        .lu_wdata(lu_wdata),
        .lu_ready(lu_ready),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .stall_pipe(stall_pipe),
        .busy(busy),
        .pend_cnt(pend_cnt)
    );

    // Every register-file write is matched in order against the expected queue.
    always @(negedge clk) begin
        if (reset && rf_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=0x%0h, required no write", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
                    n_bad++;
                    $display("FAIL rf_write: got x%0d=0x%0h, required x%0d=0x%0h",
                             rf_waddr, rf_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        pipe_we    = 1'b1;
        pipe_rd    = rd;
        pipe_wdata = d;
        if (rd != 5'd0) exp_q.push_back({rd, d});
    endtask

    task automatic pipe_idle();
        pipe_we    = 1'b0;
        pipe_rd    = 5'd0;
        pipe_wdata = '0;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v;
        lu_rd    = rd;
        lu_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        pipe_we    = 1'b1;
        pipe_rd    = 5'd4;
        pipe_wdata = 32'h44;
        lu(1'b0, 5'd0, '0);

        // Reset holds the port quiet even with a pipe request present
        smp();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pend_cnt", pend_cnt, 0);
        chk("rst_stall", stall_pipe, 0);
        tick();
        reset = 1'b1;
        pipe_idle();
        tick();

        // Idle port: buffered result retires the cycle after acceptance
        lu(1'b1, 5'd5, 32'hDEADBEEF);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        smp();
        chk("no_bypass", rf_we, 0);
        tick();
        lu(1'b0, 5'd0, '0);
        smp();
        chk("idle_busy5", busy[5], 1);
        chk("idle_pend1", pend_cnt, 1);
        tick();
        smp();
        chk("idle_busy_clear", busy, 0);
        chk("idle_pend0", pend_cnt, 0);
        tick();

        // Back-pressure: buffer fills under pipe traffic, no pass-through when full
        pipe(5'd3, 32'hA0); lu(1'b1, 5'd7, 32'h70);
        smp(); tick();
        pipe(5'd3, 32'hA1); lu(1'b1, 5'd8, 32'h80);
        smp(); tick();
        pipe(5'd3, 32'hA2); lu(1'b1, 5'd9, 32'h90);
        smp();
        chk("bp_ready_low", lu_ready, 0);
        chk("bp_pend2", pend_cnt, 2);
        chk("bp_busy", busy, 32'h0000_0180);
        tick();
        pipe_idle();
        exp_q.push_back({5'd7, 32'h70});
        exp_q.push_back({5'd8, 32'h80});
        smp();
        chk("bp_full_pop_ready", lu_ready, 0);
        tick();
        smp();
        chk("bp_ready_back", lu_ready, 1);
        exp_q.push_back({5'd9, 32'h90});
        tick();
        lu(1'b0, 5'd0, '0);
        smp(); tick();
        smp();
        chk("bp_drained", pend_cnt, 0);
        tick();

        // WAW kill: newer pipe write to x9 kills the older buffered x9
        pipe(5'd3, 32'hB0); lu(1'b1, 5'd9, 32'h1);
        smp(); tick();
        lu(1'b0, 5'd0, '0);
        pipe(5'd9, 32'h2);
        smp();
        chk("waw_busy_before", busy[9], 1);
        tick();
        pipe_idle();
        smp();
        chk("waw_busy_cleared", busy[9], 0);
        chk("waw_pend_killed", pend_cnt, 1);
        chk("waw_killed_no_we", rf_we, 0);
        tick();
        smp();
        chk("waw_pend0", pend_cnt, 0);
        tick();

        // Same-cycle enqueue is newer than the pipe write and survives
        pipe(5'd9, 32'h3); lu(1'b1, 5'd9, 32'h4);
        exp_q.push_back({5'd9, 32'h4});
        smp(); tick();
        pipe_idle(); lu(1'b0, 5'd0, '0);
        smp();
        chk("waw_same_cycle_live", busy[9], 1);
        tick();
        smp();
        chk("waw_same_pend0", pend_cnt, 0);
        tick();

        // x0 filter on both sources
        pipe(5'd0, 32'h55); lu(1'b1, 5'd0, 32'h66);
        smp();
        chk("x0_pipe_no_we", rf_we, 0);
        chk("x0_lu_ready", lu_ready, 1);
        tick();
        pipe_idle(); lu(1'b0, 5'd0, '0);
        smp();
        chk("x0_pend_unchanged", pend_cnt, 0);
        tick();

        // Reset mid-operation discards the buffered x10
        pipe(5'd3, 32'hD0); lu(1'b1, 5'd10, 32'h100);
        smp(); tick();
        pipe(5'd3, 32'hD1); lu(1'b0, 5'd0, '0);
        smp(); tick();
        pipe_idle();
        reset = 1'b0;
        smp();
        chk("midrst_no_we", rf_we, 0);
        chk("midrst_pend0", pend_cnt, 0);
        chk("midrst_busy0", busy, 0);
        tick();
        reset = 1'b1;
        smp();
        chk("midrst_after_pend0", pend_cnt, 0);
        tick();

        // Starvation: x7 enqueued under continuous pipe traffic
        pipe(5'd3, 32'hC0); lu(1'b1, 5'd7, 32'h77);
        smp(); tick();
        lu(1'b0, 5'd0, '0);
`ifdef WBARB_STARVE_GUARD_EN
        for (int k = 1; k <= 4; k++) begin
            pipe(5'd3, 32'hC0 + 32'(k));
            smp();
            chk("starve_no_stall_yet", stall_pipe, 0);
            tick();
        end
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'hC5;
        exp_q.push_back({5'd7, 32'h77});
        smp();
        chk("starve_stall", stall_pipe, 1);
        chk("starve_waddr", rf_waddr, 7);
        tick();
        pipe(5'd3, 32'hC5);
        smp();
        chk("starve_stall_release", stall_pipe, 0);
        tick();
        pipe_idle();
        smp();
        chk("starve_pend0", pend_cnt, 0);
        tick();
`else
        for (int k = 1; k <= 7; k++) begin
            pipe(5'd3, 32'hC0 + 32'(k));
            smp();
            chk("starve_no_stall", stall_pipe, 0);
            tick();
        end
        pipe_idle();
        exp_q.push_back({5'd7, 32'h77});
        smp();
        chk("starve_still_pending", pend_cnt, 1);
        chk("starve_busy7", busy[7], 1);
        tick();
        smp();
        chk("starve_pend0", pend_cnt, 0);
        tick();
`endif

        smp();
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
